// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake/result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opa, opb, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply (shift-add) / divide (restoring) unit, one result bit per cycle.
// Define MULDIV_SIGNED_EN to honour op[0] as the signed-operation select; otherwise all ops are unsigned.
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_div_p0;
  logic [WIDTH-1:0] mag_b_p0;
  logic [WIDTH-1:0] acc_hi_p0;
  logic [WIDTH-1:0] acc_lo_p0;

  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept   = (state == IDLE) && bus.start && !bus.flush;
  assign div_zero = bus.op[1] && (bus.opb == '0);

`ifdef MULDIV_SIGNED_EN
  logic sa;
  logic sb;
  logic neg_q_p0;
  logic neg_r_p0;

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] fix_2w(input logic [W2-1:0] v, input logic neg);
    return neg ? (~v + W2'(1)) : v;
  endfunction

  assign sa       = bus.op[0] & bus.opa[WIDTH-1];
  assign sb       = bus.op[0] & bus.opb[WIDTH-1];
  assign mag_a_in = fix_w(bus.opa, sa);
  assign mag_b_in = fix_w(bus.opb, sb);
`else
  assign mag_a_in = bus.opa;
  assign mag_b_in = bus.opb;
`endif

  // One iteration: multiply shifts the product right, divide shifts the remainder left.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_p0} + {1'b0, (acc_lo_p0[0] ? mag_b_p0 : {WIDTH{1'b0}})};
    div_shift = {acc_hi_p0, acc_lo_p0[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - mag_b_p0;
    div_ge    = (div_shift >= {1'b0, mag_b_p0});
    if (is_div_p0) begin
      nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo_p0[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo_p0[WIDTH-1:1]};
    end
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    if (is_div_p0) begin
      res_hi = fix_w(nxt_hi, neg_r_p0);
      res_lo = fix_w(nxt_lo, neg_q_p0);
    end else begin
      {res_hi, res_lo} = fix_2w({nxt_hi, nxt_lo}, neg_q_p0);
    end
`else
    res_hi = nxt_hi;
    res_lo = nxt_lo;
`endif
  end

  // Stage p0: operand magnitudes latched on accept, partial result iterated in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_p0 <= bus.op[1];
      mag_b_p0  <= mag_b_in;
      acc_hi_p0 <= '0;
      acc_lo_p0 <= mag_a_in;
`ifdef MULDIV_SIGNED_EN
      neg_q_p0  <= sa ^ sb;
      neg_r_p0  <= sa;
`endif
    end else if (state == CALC) begin
      acc_hi_p0 <= nxt_hi;
      acc_lo_p0 <= nxt_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            cnt    <= '0;
            if (div_zero) begin
              state  <= DONE;
              done_q <= 1'b1;
              hi_q   <= bus.opa;
              lo_q   <= '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
              hi_q   <= res_hi;
              lo_q   <= res_lo;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall drops in DONE so the consumer captures hi/lo while done is high.
  assign bus.stall = !rst && (((state == IDLE) && bus.start) || (state == CALC));
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl with a result scoreboard; honours MULDIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_ex_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  ex_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  ex_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int             vectors     = 0;
  int             miscompares = 0;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   last_hi;
  logic [W-1:0]   last_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic with the language operators; returns {hi, lo}.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic                  s;
    logic signed [2*W-1:0] pa, pb;
    logic signed [W-1:0]   qa, qb;
    logic [W-1:0]          q, r;
`ifdef MULDIV_SIGNED_EN
    s = o[0];
`else
    s = 1'b0;
`endif
    if (!o[1]) begin
      if (s) begin
        pa = $signed(a);
        pb = $signed(b);
        return pa * pb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    if (b == '0) return {a, {W{1'b1}}};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      qa = $signed(a);
      qb = $signed(b);
      q  = qa / qb;
      r  = qa % qb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                        input int exp_lat, input int exp_stall, input int inject_at);
    int             edges;
    int             stall_cnt;
    logic [2*W-1:0] exp_v;
    sb_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    #1 chk({tag, "_stall_req"}, 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    edges     = 1;
    stall_cnt = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      if (bus.stall === 1'b1) stall_cnt++;
      if (edges == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opa   = 32'd5;
        bus.opb   = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    if (exp_stall >= 0) chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    exp_v = sb_q.pop_front();
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_v[2*W-1:W]));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_v[W-1:0]));
    last_hi = exp_v[2*W-1:W];
    last_lo = exp_v[W-1:0];
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int         done_seen;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.start = 1'b1;
    #1;
    chk("reset_hi",    64'(bus.hi),    64'd0);
    chk("reset_lo",    64'(bus.lo),    64'd0);
    chk("reset_busy",  64'(bus.busy),  64'd0);
    chk("reset_done",  64'(bus.done),  64'd0);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 33, 32, -1);
    run_op("multu_small", 2'b00, 32'd123, 32'd456, {32'd0, 32'd56088}, 33, 32, -1);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 33, 32, -1);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32, -1);
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 32, -1);
`else
    run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB}, 33, 32, -1);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 32, -1);
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 32, -1);
`endif
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1, 0, -1);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 32, -1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = $urandom | 32'd1;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 33, 32, -1);
    end

    // Flush mid-CALC: no done, back to idle, results held.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = 32'd100;
    bus.opb   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'(last_hi));
    chk("flush_lo", 64'(bus.lo), 64'(last_lo));
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("idle_hold_hi", 64'(bus.hi), 64'(last_hi));
    chk("idle_hold_lo", 64'(bus.lo), 64'(last_lo));

    // Start while busy is ignored.
    run_op("divu_restart_ignored", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 32, 20);

    // Flush together with start in IDLE does not launch an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 32'd3;
    bus.opb   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    done_seen = 0;
    repeat (36) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("flush_start_no_done", 64'(done_seen), 64'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = 32'h0000_FFFF;
    bus.opb   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_hi",    64'(bus.hi),    64'd0);
    chk("rst_mid_lo",    64'(bus.lo),    64'd0);
    chk("rst_mid_busy",  64'(bus.busy),  64'd0);
    chk("rst_mid_done",  64'(bus.done),  64'd0);
    chk("rst_mid_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("rst_no_done", 64'(done_seen), 64'd0);
    run_op("divu_after_rst", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 32, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
